// File: rtl/counter_modn_down_pkg.sv
// Shared definitions for the counter_modn_down block.
//
// Contents:
//   state_e   - control FSM state encoding (IDLE, COUNT, DONE)
//   clamp_ld  - limits a requested load value to the top of the count range
//
// Optional feature macro used by the block: COUNTER_MODN_DOWN_RELOAD_EN
package counter_modn_down_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Returns n-1 when the requested value lies outside 0..n-1, else the value.
  // Callers zero-extend into 32 bits and truncate the result back to their
  // own count width, which keeps the helper usable for any modulus.
  function automatic logic [31:0] clamp_ld(input logic [31:0] val,
                                           input int unsigned n);
    logic [31:0] top;
    top = 32'(n - 1);
    if (val > top) return top;
    return val;
  endfunction

endpackage

// File: rtl/counter_modn_down_core.sv
// Bare down-counter register with synchronous reset/clear, load and
// decrement enable, plus a zero flag.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset (q -> 0)
//   clr    in   synchronous clear, same effect as rst
//   load   in   load ld_val into the count (beats dec)
//   ld_val in   value to load, Bits wide
//   dec    in   decrement by one; ignored while the count is already 0
//   q      out  current count, registered
//   zero   out  combinational (q == 0)
module counter_modn_down_core
  import counter_modn_down_pkg::*;
#(
  parameter  int unsigned N    = 64,
  localparam int unsigned Bits = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            load,
  input  logic [Bits-1:0] ld_val,
  input  logic            dec,
  output logic [Bits-1:0] q,
  output logic            zero
);

  logic [Bits-1:0] q_q;
  logic [Bits-1:0] q_d;

  // The zero guard means the core never wraps below 0 even if asked to.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = ld_val;
    end else if (dec && (q_q != '0)) begin
      q_d = q_q - Bits'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign zero = (q_q == '0);

endmodule

// File: rtl/counter_modn_down.sv
// Loadable mod-N down-counter / timer with a one-cycle completion pulse.
//
// A start in IDLE loads clamp(ld_val) and the counter then decrements on
// each en cycle while in COUNT. Reaching 0 passes through DONE for one cycle
// (done=1) and returns to IDLE. A load of 0 goes straight to DONE.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   clr    in   synchronous clear, same effect as rst, beats start/en
//   start  in   load request, accepted only in IDLE
//   ld_val in   initial count (Bits wide), clamped to N-1
//   en     in   decrement enable, honoured only in COUNT
//   q      out  current count, registered
//   busy   out  high while in COUNT, registered
//   done   out  one-cycle completion pulse, registered
//   zero   out  combinational (q == 0)
//
// Optional feature: define COUNTER_MODN_DOWN_RELOAD_EN for periodic mode.
// The clamped load value is kept in a reload register; each time the count
// would step from 1 to 0 it is reloaded instead, done pulses, and the FSM
// stays in COUNT. Reload values of 0 or 1 behave one-shot. Periodic
// operation ends only via clr/rst.
module counter_modn_down
  import counter_modn_down_pkg::*;
#(
  parameter  int unsigned N    = 64,
  localparam int unsigned Bits = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            start,
  input  logic [Bits-1:0] ld_val,
  input  logic            en,
  output logic [Bits-1:0] q,
  output logic            busy,
  output logic            done,
  output logic            zero
);

  state_e          state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            core_load;
  logic            core_dec;
  logic [Bits-1:0] core_val;
  logic [Bits-1:0] ld_clamped;
  logic [Bits-1:0] q_int;
  logic            zero_int;

`ifdef COUNTER_MODN_DOWN_RELOAD_EN
  logic [Bits-1:0] reload_q, reload_d;
`endif

  assign ld_clamped = Bits'(clamp_ld(32'(ld_val), N));

  counter_modn_down_core #(
    .N(N)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .load   (core_load),
    .ld_val (core_val),
    .dec    (core_dec),
    .q      (q_int),
    .zero   (zero_int)
  );

  always_comb begin
    state_d   = state_q;
    core_load = 1'b0;
    core_dec  = 1'b0;
    core_val  = ld_clamped;
    done_d    = 1'b0;
`ifdef COUNTER_MODN_DOWN_RELOAD_EN
    reload_d  = reload_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          core_load = 1'b1;
`ifdef COUNTER_MODN_DOWN_RELOAD_EN
          reload_d  = ld_clamped;
`endif
          state_d   = (ld_clamped == '0) ? ST_DONE : ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (en) begin
          if (q_int == Bits'(1)) begin
`ifdef COUNTER_MODN_DOWN_RELOAD_EN
            // Reload of 1 would pin q at 1 forever, so it finishes one-shot.
            if (reload_q > Bits'(1)) begin
              core_load = 1'b1;
              core_val  = reload_q;
              done_d    = 1'b1;
            end else begin
              core_dec  = 1'b1;
              state_d   = ST_DONE;
            end
`else
            core_dec = 1'b1;
            state_d  = ST_DONE;
`endif
          end else begin
            core_dec = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // done is registered alongside the state so it is high exactly while
    // the FSM sits in DONE (or on a periodic reload edge).
    if (state_d == ST_DONE) begin
      done_d = 1'b1;
    end
    busy_d = (state_d == ST_COUNT);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef COUNTER_MODN_DOWN_RELOAD_EN
  // Data-only register: it is always rewritten by the start that leads into
  // COUNT, so it needs no reset.
  always_ff @(posedge clk) begin
    reload_q <= reload_d;
  end
`endif

  assign q    = q_int;
  assign busy = busy_q;
  assign done = done_q;
  assign zero = zero_int;

endmodule

// File: tb/tb_counter_modn_down.sv
module tb_counter_modn_down;

  logic       clk = 1'b0;
  logic       rst, clr, start, en;
  logic [5:0] ld_val;

  logic [5:0] q0, q1;
  logic       busy0, done0, zero0;
  logic       busy1, done1, zero1;

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 1'b0;

  always #5 clk = ~clk;

  counter_modn_down #(.N(64)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .ld_val(ld_val), .en(en),
    .q(q0), .busy(busy0), .done(done0), .zero(zero0)
  );

  counter_modn_down #(.N(48)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .ld_val(ld_val), .en(en),
    .q(q1), .busy(busy1), .done(done1), .zero(zero1)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Behavioural reference: per instance, the remaining count, whether a
  // countdown is running, the remembered period and the completion pulse.
`ifdef COUNTER_MODN_DOWN_RELOAD_EN
  localparam bit PERIODIC = 1'b1;
`else
  localparam bit PERIODIC = 1'b0;
`endif
  int m_mod[2] = '{64, 48};
  int m_cnt[2] = '{0, 0};
  int m_per[2] = '{0, 0};
  bit m_run[2] = '{0, 0};
  bit m_fin[2] = '{0, 0};   // in the one-cycle finishing slot
  bit m_pulse[2] = '{0, 0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst || clr) begin
        m_cnt[k] = 0; m_run[k] = 0; m_fin[k] = 0; m_pulse[k] = 0;
      end else if (m_fin[k]) begin
        m_fin[k] = 0; m_pulse[k] = 0;
      end else if (m_run[k]) begin
        m_pulse[k] = 0;
        if (en) begin
          if (m_cnt[k] == 1 && PERIODIC && m_per[k] > 1) begin
            m_cnt[k] = m_per[k]; m_pulse[k] = 1;
          end else begin
            m_cnt[k] = m_cnt[k] - 1;
            if (m_cnt[k] == 0) begin
              m_run[k] = 0; m_fin[k] = 1; m_pulse[k] = 1;
            end
          end
        end
      end else begin
        m_pulse[k] = 0;
        if (start) begin
          m_cnt[k] = (int'(ld_val) > m_mod[k] - 1) ? m_mod[k] - 1 : int'(ld_val);
          m_per[k] = m_cnt[k];
          if (m_cnt[k] == 0) begin
            m_fin[k] = 1; m_pulse[k] = 1;
          end else begin
            m_run[k] = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_q0",    q0,    m_cnt[0]);
      check("model_busy0", busy0, m_run[0]);
      check("model_done0", done0, m_pulse[0]);
      check("model_zero0", zero0, m_cnt[0] == 0);
      check("model_q1",    q1,    m_cnt[1]);
      check("model_busy1", busy1, m_run[1]);
      check("model_done1", done1, m_pulse[1]);
      check("model_zero1", zero1, m_cnt[1] == 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int pulses;
    rst = 1'b1; clr = 1'b0; start = 1'b0; en = 1'b0; ld_val = '0;
    cyc();
    cmp_on = 1'b1;
    cyc();
    rst = 1'b0;
    check("reset_q", q0, 0);
    check("reset_busy", busy0, 0);
    check("reset_done", done0, 0);
    check("reset_zero", zero0, 1);

    // Reset in the middle of a countdown.
    start = 1'b1; ld_val = 6'd40; en = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc();
    check("midrst_pre_q", q0, 37);
    rst = 1'b1;
    cyc();
    check("midrst_q", q0, 0);
    check("midrst_busy", busy0, 0);
    check("midrst_done", done0, 0);
    check("midrst_zero", zero0, 1);
    cyc();
    rst = 1'b0;

`ifndef COUNTER_MODN_DOWN_RELOAD_EN
    // Load 5, continuous enable.
    start = 1'b1; ld_val = 6'd5; en = 1'b1;
    cyc();
    check("l5_q_start", q0, 5);
    check("l5_busy_start", busy0, 1);
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check("l5_q", q0, 5 - i);
      check("l5_done_early", done0, 0);
    end
    cyc();
    check("l5_q_end", q0, 0);
    check("l5_done", done0, 1);
    check("l5_busy_end", busy0, 0);
    cyc();
    check("l5_done_after", done0, 0);
    check("l5_busy_after", busy0, 0);

    // Load 10 with alternating enable and a stray start mid-count.
    start = 1'b1; ld_val = 6'd10; en = 1'b0;
    cyc();
    check("l10_q_start", q0, 10);
    for (int i = 0; i < 20; i++) begin
      en = (i % 2 == 0);
      start = (i == 4);
      ld_val = 6'd3;
      cyc();
      check("l10_q", q0, 10 - (i / 2 + 1));
      check("l10_done", done0, i == 18);
      check("l10_busy", busy0, i < 18);
    end
    start = 1'b0;

    // Full-range load of 63.
    start = 1'b1; ld_val = 6'd63; en = 1'b1;
    cyc();
    check("l63_q_start", q0, 63);
    start = 1'b0;
    n = 0;
    while (!done0 && n < 200) begin
      cyc();
      n++;
    end
    check("l63_cycles", n, 63);
    cyc();
`endif

    // Load 0: done one cycle after start, never busy.
    start = 1'b1; ld_val = 6'd0; en = 1'b1;
    cyc();
    check("l0_done", done0, 1);
    check("l0_busy", busy0, 0);
    check("l0_q", q0, 0);
    start = 1'b0;
    cyc();
    check("l0_done_after", done0, 0);
    check("l0_busy_after", busy0, 0);

    // Clamp on the N=48 instance.
    start = 1'b1; ld_val = 6'd60; en = 1'b0;
    cyc();
    check("clamp_q48", q1, 47);
    check("clamp_q64", q0, 60);
    start = 1'b0; clr = 1'b1;
    cyc();
    check("clamp_clr_q", q1, 0);
    check("clamp_clr_busy", busy1, 0);
    clr = 1'b0;

    // clr with en at q=1 suppresses the done pulse.
    start = 1'b1; ld_val = 6'd2; en = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    check("clr_pre_q", q0, 1);
    clr = 1'b1;
    cyc();
    check("clr_q", q0, 0);
    check("clr_busy", busy0, 0);
    check("clr_done", done0, 0);
    clr = 1'b0;
    cyc();
    check("clr_done_after", done0, 0);

`ifdef COUNTER_MODN_DOWN_RELOAD_EN
    // Periodic mode with period 3.
    start = 1'b1; ld_val = 6'd3; en = 1'b1;
    cyc();
    check("rl_q_start", q0, 3);
    start = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check("rl_q", q0, (k % 3 == 0) ? 3 : 3 - (k % 3));
      check("rl_done", done0, k % 3 == 0);
      check("rl_busy", busy0, 1);
      pulses += int'(done0);
    end
    check("rl_pulses", pulses, 4);
    clr = 1'b1;
    cyc();
    check("rl_clr_busy", busy0, 0);
    clr = 1'b0;
`else
    pulses = 0;
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 99) == 0);
      clr    = ($urandom_range(0, 39) == 0);
      start  = ($urandom_range(0, 3) == 0);
      en     = ($urandom_range(0, 3) != 0);
      ld_val = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 3))
                                           : 6'($urandom_range(0, 63));
      cyc();
    end
    rst = 1'b0; clr = 1'b0; start = 1'b0; en = 1'b0;
    cyc();
    cmp_on = 1'b0;
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_modn_down.md
Name: counter_modn_down

Overview:
- Loadable mod-N down-counter/timer; the count-down counterpart to the team's mod-N up-counter.
- Accepts a start request with a load value, decrements on `en`, and signals completion with a one-cycle `done` pulse.
- Used by datapath controllers for iteration and delay budgets, where the up-counter's carry-out is not suitable.
- Internally: a bare down-counter core plus a 3-state control FSM.

Parameters:
- N, 64, modulus. Count range 0..N-1; must be >= 2.
- Bits, localparam = $clog2(N), width of count and load value.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- clr  input  1  synchronous clear; same effect as rst, next-highest priority after rst
- start  input  1  request to load `ld_val` and begin counting; accepted only in IDLE
- ld_val  input  Bits  initial count, sampled on the accepted start cycle
- en  input  1  decrement enable, honoured only in COUNT
- q  output  Bits  current count, registered
- busy  output  1  high while in COUNT
- done  output  1  registered one-cycle completion pulse
- zero  output  1  combinational: (q == 0)

Behaviour:
- Reset (rst=1 at a clock edge):
  - q=0, state=IDLE, busy=0, done=0; zero=1 as a consequence.
  - Also applies mid-count; any pending done is dropped.
- clr=1 (with rst=0): identical effect to rst. clr beats start and en in the same cycle.
- States: IDLE, COUNT, DONE. Encoding lives in the shared package.
- IDLE:
  - start=1 → q<=clamp(ld_val), where clamp returns N-1 if ld_val > N-1.
  - If clamp(ld_val)==0 → DONE; else → COUNT.
  - start=0 → hold q.
- COUNT:
  - busy=1.
  - en=1 and q>1 → q<=q-1.
  - en=1 and q==1 → q<=0, → DONE.
  - en=0 → hold q and state.
  - start is ignored.
- DONE:
  - done=1 for exactly this cycle; busy=0.
  - Unconditionally → IDLE.
  - start in DONE is ignored; the requester must re-assert it in IDLE.
- Latency (en held high, accepted start at edge 0, load L >= 1):
  - q=L after edge 0.
  - q=0 and done=1 after edge L.
  - IDLE after edge L+1.
  - Total from start to done = L+1 cycles.
  - L=0: done=1 after edge 1.
- Arithmetic: Bits-wide unsigned decrement. The core never decrements from 0, so no underflow wrap occurs in one-shot mode.
- busy and done are never high together.

Optional Feature:
- Macro: COUNTER_MODN_DOWN_RELOAD_EN.
- Defined (periodic mode):
  - clamp(ld_val) is captured into a reload register on the accepted start.
  - In COUNT, en=1 and q==1 → q<=reload, done pulses one cycle, state stays COUNT, busy stays 1.
  - Period = reload value.
  - A reload of 0, or of 1 (which reloads 1 forever), is treated as one-shot.
  - Exit only via clr/rst.
- Undefined: one-shot behaviour exactly as above; no reload register is synthesised.

Decomposition:
- Shared package holds:
  - the state enum (IDLE=2'd0, COUNT=2'd1, DONE=2'd2);
  - a clamp helper function parameterised on N.
- Natural sub-module: counter_modn_down_core.
  - Bare register with sync rst/clr, load, and decrement enable, plus the zero flag.
  - Instantiated by the FSM wrapper.

Test Plan:
- rst high 2 cycles mid-count (q=37) → q=0, busy=0, done=0, zero=1 on the next edge.
- N=64, start with ld_val=5, en=1 continuously → q sequence 5,4,3,2,1,0; done high only on the cycle q=0 (6 cycles after start); busy low afterwards.
- ld_val=10, en toggled 1,0,1,0… → q decrements only on en=1 cycles; done after 10 enabled cycles. A start pulse during COUNT does not change q.
- ld_val=0 → done pulses 1 cycle after start, busy never asserted. ld_val=63 → full 64-cycle count.
- N=48, ld_val=60 → clamped: q=47 after start.
- clr asserted together with en at q=1 → q=0, IDLE, no done pulse.
- With RELOAD_EN defined, ld_val=3, en=1 for 12 cycles → done every 3 cycles (4 pulses), q pattern 3,2,1,3,2,1…; busy stays 1 until clr.
